univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register: the next generation of the team's 4-bit four-mode shift register. It adds a WIDTH parameter, rotate and arithmetic-shift modes, a synchronous clear, and a multi-step shift engine. The engine executes a counted burst of shifts, one per clock, and signals completion with a busy/done handshake. The block serves as the general-purpose shifter and serialiser in the lab datapath designs.

## Interface
Parameters:
- WIDTH, 8: register width in bits; legal range 2 or more.
- CNT_W, $clog2(WIDTH+1): width of the step counter and `amt`. Derived; never overridden.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  reset. One clock; reset is asynchronous and active-low.
- op  in  3  operation select; encoding given under Operation.
- SR  in  1  serial input for right shifts; enters at Q[WIDTH-1].
- SL  in  1  serial input for left shifts; enters at Q[0].
- D  in  WIDTH  parallel load data.
- start  in  1  request a multi-step shift of `amt` steps using `op`.
- amt  in  CNT_W  number of steps; legal range 0..2^CNT_W-1.
- Q  out  WIDTH  register contents.
- busy  out  1  multi-step burst in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- `op` encoding; each step is one shift by one bit position:
  - 000 HOLD: Q unchanged.
  - 001 SHR: Q ← {SR, Q[WIDTH-1:1]}.
  - 010 SHL: Q ← {Q[WIDTH-2:0], SL}.
  - 011 LOAD: Q ← D.
  - 100 ROR: Q ← {Q[0], Q[WIDTH-1:1]}.
  - 101 ROL: Q ← {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 110 ASR: Q ← {Q[WIDTH-1], Q[WIDTH-1:1]}.
  - 111 SCLR: Q ← 0, synchronous.
- Shift-class ops: 001, 010, 100, 101, 110.
- State machine, IDLE and RUN:
  - IDLE, start=0: `op` executes once per edge.
  - IDLE, start=1, `op` not shift-class: `start` is ignored and `op` executes once.
  - IDLE, start=1, `op` shift-class, amt≠0: latch `op` into op_q and `amt` into cnt; Q unchanged; go to RUN.
  - IDLE, start=1, `op` shift-class, amt=0: Q unchanged; done=1 on the next cycle; stay in IDLE; busy never asserts.
  - RUN, each edge: Q ← step(op_q); cnt ← cnt−1. When cnt=1 at the edge: go to IDLE and set done=1.
- In RUN, the `op`, `start`, `amt` and `D` inputs are ignored.
- SR and SL are sampled live on every step. They are not latched at start.
- Reset (clr=0) at any time, including mid-burst, forces the following immediately:
  - Q=0.
  - busy=0.
  - done=0.
  - cnt=0.
  - state IDLE.
  - op_q=HOLD.

## Timing
- Reset values: Q=0, busy=0, done=0.
- Single-step ops: Q updates on the edge where `op` is sampled. Latency 1.
- Burst start at edge E0:
  - busy=1 from after E0 through edge E(amt).
  - Shift steps occur at edges E1..E(amt).
  - done=1 for exactly the cycle after E(amt).
  - busy and done are never high together.
- Back-to-back bursts: a new `start` is accepted on the edge where done is high. That edge is IDLE.
- amt=0 request: done pulses one cycle after E0.
- A burst of `amt` steps is always exactly `amt` shifts. No clamping at WIDTH; rotates wrap.

## Configuration
- Macro: UNIV_SHIFT_ROTATE_EN.
- Defined: ROR and ROL behave as specified above.
- Undefined:
  - 100 and 101 act as HOLD.
  - 100 and 101 are not shift-class, so `start` with them is ignored.
  - No rotate logic is synthesised.

## Structure
- Package univ_shift_pkg holds:
  - the `op` enum (OP_HOLD … OP_SCLR);
  - the FSM state enum (ST_IDLE, ST_RUN);
  - the function is_shift_op().
- Sub-module univ_shift_step: combinational next-value function, step(op, Q, SR, SL, D) → next Q, shared by the single-step and burst paths.
- The top level holds the FSM, cnt, op_q and the Q register.

## Test plan
- LOAD D=8'hA5, then SHR with SR=1 → Q=8'hD2 after one edge; busy=0 and done=0 throughout.
- Q=8'h01, start with ROR and amt=3 → busy high for 3 cycles; Q=8'h20; done pulses once on the 4th cycle after start.
- Q=8'h80, start with ASR and amt=2 → Q=8'hC0, then Q=8'hE0; done pulses once. During the burst, drive op=LOAD with D=8'hFF → ignored.
- start with SHL and amt=0 → Q unchanged; busy stays 0; done pulses 1 cycle later. start with op=LOAD → plain load; no done pulse.
- Start a burst with amt=5, assert clr=0 after 2 steps → Q, busy and done become 0 immediately. After release, the block is IDLE and HOLD keeps Q=0.
- Build without UNIV_SHIFT_ROTATE_EN, Q=8'h01, op=ROR with start=1 → Q stays 8'h01; no busy and no done.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg: shared types and helpers for the universal shift register.
//   op_e        - operation select encoding (OP_HOLD .. OP_SCLR)
//   state_e     - burst engine states (ST_IDLE, ST_RUN)
//   is_shift_op - true for ops that may be repeated by the burst engine
// Optional feature macro: UNIV_SHIFT_ROTATE_EN (rotates become shift-class).
package univ_shift_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_SCLR = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ops that a start request turns into a counted burst.
  function automatic logic is_shift_op(op_e op);
    logic res;
    res = 1'b0;
    case (op)
      OP_SHR, OP_SHL, OP_ASR: res = 1'b1;
`ifdef UNIV_SHIFT_ROTATE_EN
      OP_ROR, OP_ROL:         res = 1'b1;
`endif
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control/data bundle of the universal shift register.
//   op[2:0], SR, SL, D[WIDTH-1:0], start, amt[CNT_W-1:0] : requester -> shifter
//   Q[WIDTH-1:0], busy, done                              : shifter -> requester
// master: the requester side; slave: the shift register.
interface univ_shift_reg_if #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
);

  logic [2:0]       op;
  logic             SR;
  logic             SL;
  logic [WIDTH-1:0] D;
  logic             start;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             done;

  modport master (
    output op, SR, SL, D, start, amt,
    input  Q, busy, done
  );

  modport slave (
    input  op, SR, SL, D, start, amt,
    output Q, busy, done
  );

endinterface

// File: rtl/univ_shift_step.sv
// univ_shift_step: combinational one-step next-value function for the register.
//   op_i     - operation to apply
//   q_i      - current register value
//   sr_i     - serial input entering at the MSB on right shifts
//   sl_i     - serial input entering at the LSB on left shifts
//   d_i      - parallel load data
//   q_next_c - register value after one step
// With UNIV_SHIFT_ROTATE_EN undefined the rotate encodings fall through to hold.
module univ_shift_step
  import univ_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             sr_i,
  input  logic             sl_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_next_c
);

  // One-bit-position step selected by op_i.
  always_comb begin
    q_next_c = q_i;
    case (op_i)
      OP_SHR:  q_next_c = {sr_i, q_i[WIDTH-1:1]};
      OP_SHL:  q_next_c = {q_i[WIDTH-2:0], sl_i};
      OP_LOAD: q_next_c = d_i;
`ifdef UNIV_SHIFT_ROTATE_EN
      OP_ROR:  q_next_c = {q_i[0], q_i[WIDTH-1:1]};
      OP_ROL:  q_next_c = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
`endif
      OP_ASR:  q_next_c = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      OP_SCLR: q_next_c = '0;
      default: q_next_c = q_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with a counted
// multi-step shift engine (busy/done handshake).
//   clk  - rising-edge clock
//   clr  - asynchronous active-low reset
//   bus  - univ_shift_reg_if.slave: op, SR, SL, D, start, amt in; Q, busy, done out
// Optional feature macro: UNIV_SHIFT_ROTATE_EN enables ROR/ROL; when undefined
// those encodings hold Q and cannot start a burst.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              clr,
  univ_shift_reg_if.slave   bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  op_e              op_q,    op_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  op_e              op_in_c;
  op_e              step_op_c;
  logic [WIDTH-1:0] step_q_c;

  assign op_in_c = op_e'(bus.op);

  // A running burst replays the latched op; otherwise the live op is applied.
  assign step_op_c = (state_q == ST_RUN) ? op_q : op_in_c;

  univ_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i     (step_op_c),
    .q_i      (q_q),
    .sr_i     (bus.SR),
    .sl_i     (bus.SL),
    .d_i      (bus.D),
    .q_next_c (step_q_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_d     = q_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && is_shift_op(op_in_c)) begin
          // Burst request: Q is left alone on the accepting edge.
          if (bus.amt != '0) begin
            state_d = ST_RUN;
            op_d    = op_in_c;
            cnt_d   = bus.amt;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          q_d = step_q_c;
        end
      end
      ST_RUN: begin
        q_d   = step_q_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.Q    = q_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg (WIDTH=8).
// A queue-based reference model predicts Q/busy/done every cycle; literal
// expectations at key points pin the model to hand-computed values.
module tb_univ_shift_reg;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] SHR  = 3'b001;
  localparam logic [2:0] SHL  = 3'b010;
  localparam logic [2:0] LOAD = 3'b011;
  localparam logic [2:0] ROR  = 3'b100;
  localparam logic [2:0] ROL  = 3'b101;
  localparam logic [2:0] ASR  = 3'b110;
  localparam logic [2:0] SCLR = 3'b111;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_fail;

  univ_shift_reg_if #(.WIDTH(8)) bus ();

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_q;
  logic        m_done;
  logic [2:0]  pend[$];

  function automatic logic shift_class(input logic [2:0] op);
`ifdef UNIV_SHIFT_ROTATE_EN
    return (op == SHR) || (op == SHL) || (op == ASR) || (op == ROR) || (op == ROL);
`else
    return (op == SHR) || (op == SHL) || (op == ASR);
`endif
  endfunction

  function automatic logic [7:0] apply(input logic [2:0] op, input logic [7:0] q);
    logic [7:0] r;
    r = q;
    case (op)
      SHR:  r = (q >> 1) | ({7'd0, bus.SR} << 7);
      SHL:  r = (q << 1) | {7'd0, bus.SL};
      LOAD: r = bus.D;
`ifdef UNIV_SHIFT_ROTATE_EN
      ROR:  r = (q >> 1) | (q << 7);
      ROL:  r = (q << 1) | (q >> 7);
`endif
      ASR:  r = 8'($signed(q) >>> 1);
      SCLR: r = 8'd0;
      default: r = q;
    endcase
    return r;
  endfunction

  // Each accepted burst becomes a queue of pending single steps.
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_q    = 8'd0;
      m_done = 1'b0;
      pend.delete();
    end else begin
      m_done = 1'b0;
      if (pend.size() != 0) begin
        m_q = apply(pend.pop_front(), m_q);
        if (pend.size() == 0) m_done = 1'b1;
      end else if (bus.start && shift_class(bus.op)) begin
        if (bus.amt == 0) m_done = 1'b1;
        else for (int i = 0; i < int'(bus.amt); i++) pend.push_back(bus.op);
      end else begin
        m_q = apply(bus.op, m_q);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_q",    32'(bus.Q),    32'(m_q));
    chk("model_busy", 32'(bus.busy), 32'(pend.size() != 0));
    chk("model_done", 32'(bus.done), 32'(m_done));
    if (bus.busy && bus.done) chk("busy_and_done", 32'(1), 32'(0));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] op, input logic st, input int amt,
                       input logic [7:0] d, input logic sr, input logic sl);
    bus.op    = op;
    bus.start = st;
    bus.amt   = 4'(amt);
    bus.D     = d;
    bus.SR    = sr;
    bus.SL    = sl;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b0;
    drive(HOLD, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    repeat (2) tick();
    chk("reset_q",    32'(bus.Q),    32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    clr = 1'b1;
    tick();

    // LOAD then single SHR with SR=1
    drive(LOAD, 1'b0, 0, 8'hA5, 1'b0, 1'b0); tick();
    chk("load_a5", 32'(bus.Q), 32'hA5);
    drive(SHR, 1'b0, 0, 8'h00, 1'b1, 1'b0); tick();
    chk("shr_d2", 32'(bus.Q), 32'hD2);
    chk("shr_busy", 32'(bus.busy), 32'h0);
    chk("shr_done", 32'(bus.done), 32'h0);
    drive(SHL, 1'b0, 0, 8'h00, 1'b0, 1'b1); tick();
    chk("shl_a5", 32'(bus.Q), 32'hA5);
    drive(SCLR, 1'b0, 0, 8'h00, 1'b0, 1'b0); tick();
    chk("sclr", 32'(bus.Q), 32'h0);

`ifdef UNIV_SHIFT_ROTATE_EN
    // ROR burst of 3 from 01
    drive(LOAD, 1'b0, 0, 8'h01, 1'b0, 1'b0); tick();
    drive(ROR, 1'b1, 3, 8'h00, 1'b0, 1'b0); tick();
    chk("ror_e0_busy", 32'(bus.busy), 32'h1);
    chk("ror_e0_q", 32'(bus.Q), 32'h01);
    drive(HOLD, 1'b0, 0, 8'h00, 1'b0, 1'b0); tick(); tick();
    chk("ror_e2_q", 32'(bus.Q), 32'h40);
    tick();
    chk("ror_q", 32'(bus.Q), 32'h20);
    chk("ror_done", 32'(bus.done), 32'h1);
    chk("ror_busy_off", 32'(bus.busy), 32'h0);
    tick();
    chk("ror_done_off", 32'(bus.done), 32'h0);
    // ROL burst of 9 wraps past WIDTH
    drive(LOAD, 1'b0, 0, 8'h01, 1'b0, 1'b0); tick();
    drive(ROL, 1'b1, 9, 8'h00, 1'b0, 1'b0); tick();
    drive(HOLD, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    repeat (9) tick();
    chk("rol9_q", 32'(bus.Q), 32'h02);
    chk("rol9_done", 32'(bus.done), 32'h1);
    tick();
`else
    // Rotate disabled: ROR/ROL hold and never start a burst
    drive(LOAD, 1'b0, 0, 8'h01, 1'b0, 1'b0); tick();
    drive(ROR, 1'b1, 3, 8'h00, 1'b0, 1'b0); tick();
    chk("nrot_q", 32'(bus.Q), 32'h01);
    chk("nrot_busy", 32'(bus.busy), 32'h0);
    drive(ROL, 1'b1, 2, 8'h00, 1'b0, 1'b0); tick();
    chk("nrol_q", 32'(bus.Q), 32'h01);
    chk("nrot_done", 32'(bus.done), 32'h0);
    drive(HOLD, 1'b0, 0, 8'h00, 1'b0, 1'b0); tick();
    chk("nrot_done2", 32'(bus.done), 32'h0);
`endif

    // ASR burst of 2 from 80, LOAD FF ignored while running
    drive(LOAD, 1'b0, 0, 8'h80, 1'b0, 1'b0); tick();
    drive(ASR, 1'b1, 2, 8'h00, 1'b0, 1'b0); tick();
    chk("asr_e0_q", 32'(bus.Q), 32'h80);
    drive(LOAD, 1'b0, 0, 8'hFF, 1'b0, 1'b0); tick();
    chk("asr_c0", 32'(bus.Q), 32'hC0);
    chk("asr_busy", 32'(bus.busy), 32'h1);
    drive(HOLD, 1'b0, 0, 8'h00, 1'b0, 1'b0); tick();
    chk("asr_e0", 32'(bus.Q), 32'hE0);
    chk("asr_done", 32'(bus.done), 32'h1);
    tick();
    chk("asr_done_off", 32'(bus.done), 32'h0);

    // amt=0 request, then start with a non-shift op
    drive(SHL, 1'b1, 0, 8'h00, 1'b0, 1'b1); tick();
    chk("amt0_q", 32'(bus.Q), 32'hE0);
    chk("amt0_busy", 32'(bus.busy), 32'h0);
    chk("amt0_done", 32'(bus.done), 32'h1);
    drive(LOAD, 1'b1, 3, 8'h3C, 1'b0, 1'b0); tick();
    chk("start_load_q", 32'(bus.Q), 32'h3C);
    chk("start_load_done", 32'(bus.done), 32'h0);
    chk("start_load_busy", 32'(bus.busy), 32'h0);

    // Back-to-back: new start accepted on the done cycle
    drive(LOAD, 1'b0, 0, 8'h81, 1'b0, 1'b0); tick();
    drive(SHL, 1'b1, 1, 8'h00, 1'b0, 1'b0); tick();
    drive(SHR, 1'b1, 2, 8'h00, 1'b0, 1'b0); tick();
    chk("b2b_q1", 32'(bus.Q), 32'h02);
    chk("b2b_done1", 32'(bus.done), 32'h1);
    tick();
    chk("b2b_busy2", 32'(bus.busy), 32'h1);
    drive(HOLD, 1'b0, 0, 8'h00, 1'b0, 1'b0); tick(); tick();
    chk("b2b_q2", 32'(bus.Q), 32'h00);
    chk("b2b_done2", 32'(bus.done), 32'h1);
    tick();

    // Long SHL burst (amt > WIDTH), SL sampled live each step
    drive(LOAD, 1'b0, 0, 8'hA5, 1'b0, 1'b0); tick();
    drive(SHL, 1'b1, 10, 8'h00, 1'b0, 1'b1); tick();
    for (int i = 0; i < 10; i++) begin
      drive(HOLD, 1'b0, 0, 8'h00, 1'b0, 1'(i & 1));
      tick();
    end
    chk("shl10_q", 32'(bus.Q), 32'h55);
    chk("shl10_done", 32'(bus.done), 32'h1);
    tick();

    // Reset mid-burst
    drive(LOAD, 1'b0, 0, 8'hF0, 1'b0, 1'b0); tick();
    drive(SHR, 1'b1, 5, 8'h00, 1'b1, 1'b0); tick();
    drive(HOLD, 1'b0, 0, 8'h00, 1'b1, 1'b0); tick(); tick();
    chk("mid_q", 32'(bus.Q), 32'hFC);
    chk("mid_busy", 32'(bus.busy), 32'h1);
    #1 clr = 1'b0;
    #1;
    chk("rst_mid_q", 32'(bus.Q), 32'h0);
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    chk("rst_mid_done", 32'(bus.done), 32'h0);
    tick();
    clr = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_q", 32'(bus.Q), 32'h0);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);
    chk("post_rst_done", 32'(bus.done), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
